scramble_checker: RTL and testbench
===================================

SCRAMBLE_CHECKER -- requirements
Module: scramble_checker

Interface
REQ-001 The module SHALL have parameter MAX_STRIKES, default 3, legal range 1..3: number of wrong guesses that ends a round as lost.
REQ-002 The module SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 The module SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 The module SHALL have port done, input, 1, load strobe from the scrambler; index1..index6 and mode are valid while high.
REQ-005 The module SHALL have port mode, input, 2, round length select: 00 -> 4, 01 -> 5, 10 -> 6, 11 -> 6 positions.
REQ-006 The module SHALL have ports index1..index6, input, 3 each, scrambled sequence; legal values 1..6.
REQ-007 The module SHALL have port guess, input, 3, player entry.
REQ-008 The module SHALL have port guess_valid, input, 1, guess is sampled on each clk edge where this is high.
REQ-009 The module SHALL have port restart, input, 1, returns a finished round to idle.
REQ-010 The module SHALL have port ready, output, 1, high in IDLE.
REQ-011 The module SHALL have port playing, output, 1, high in PLAY.
REQ-012 The module SHALL have port pos, output, 3, count of positions matched so far.
REQ-013 The module SHALL have port strikes, output, 2, count of wrong guesses this round.
REQ-014 The module SHALL have ports hit, miss and bad_guess, output, 1 each, one-cycle event pulses.
REQ-015 The module SHALL have ports win and lose, output, 1 each, levels held until restart or reset.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, PLAY, WIN and LOSE.
REQ-018 IDLE, done=1: capture index1..6 and the length L (from mode) into internal registers; pos=0, strikes=0; go to PLAY next cycle.
REQ-019 PLAY, guess_valid=1, guess in 1..6, guess equal to stored index(pos+1): pos increments and hit pulses for one cycle.
REQ-020 If the incremented pos equals L, the state SHALL move to WIN in the same edge, with win=1.
REQ-021 PLAY, guess_valid=1, guess in 1..6, guess not equal to stored index(pos+1): strikes increments, pos is held and miss pulses for one cycle.
REQ-022 If the incremented strikes equals MAX_STRIKES, the state SHALL move to LOSE in the same edge, with lose=1.
REQ-023 PLAY, guess_valid=1, guess of 0 or 7: bad_guess pulses for one cycle; pos and strikes are unchanged.
REQ-024 PLAY, done=1: reload the sequence and L, clear pos and strikes, and stay in PLAY; done takes priority over a simultaneous guess_valid, which is discarded with no pulse.
REQ-025 WIN or LOSE: pos, strikes and win/lose SHALL hold; guess_valid and done SHALL be ignored.
REQ-026 WIN or LOSE, restart=1: go to IDLE next cycle, clearing pos, strikes, win and lose.
REQ-027 restart SHALL be ignored in IDLE and PLAY.
REQ-028 The stored sequence and L SHALL NOT change outside a done capture, so later changes on index1..6 or mode during PLAY have no effect.
REQ-029 Latency SHALL be one edge: a guess sampled at edge N is reflected in pos, strikes and the pulses after edge N.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, ready=1, and all other outputs and stored indices to 0, including mid-round.
REQ-031 On rst release, the first done SHALL be honoured on the first rising edge at which it is sampled high.

Verification
REQ-032 Reset test: assert rst during PLAY with pos=2 -> immediately ready=1, playing=0, pos=0, strikes=0, win=0, lose=0.
REQ-033 Win test: mode=00, indices 3,1,4,2,6,5, done pulse, then guesses 3,1,4,2 -> hit pulses four times, pos=4, win=1; then restart -> ready=1.
REQ-034 Lose test: MAX_STRIKES=3, mode=10, indices 1..6, then guesses 2,1,5,5 -> pos=1, strikes=3, lose=1; a further guess produces no pulse.
REQ-035 Bad-guess test: in PLAY, guesses 0 and 7 -> bad_guess pulses twice, pos and strikes unchanged.
REQ-036 Priority test: done and guess_valid high on the same edge in PLAY with pos=3 -> pos=0, strikes=0, no hit or miss pulse, new sequence used.
REQ-037 Mode test: mode=01 -> win only after 5 correct guesses; mode changed to 00 mid-round -> L stays 5.

Source files
------------

// File: rtl/scramble_checker.sv
// Sequence-guessing round checker: captures a scrambled sequence on done, then
// scores player guesses position by position until the round is won or lost.
module scramble_checker #(
    parameter int MAX_STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [1:0] mode,
    input  logic [2:0] index1,
    input  logic [2:0] index2,
    input  logic [2:0] index3,
    input  logic [2:0] index4,
    input  logic [2:0] index5,
    input  logic [2:0] index6,
    input  logic [2:0] guess,
    input  logic       guess_valid,
    input  logic       restart,
    output logic       ready,
    output logic       playing,
    output logic [2:0] pos,
    output logic [1:0] strikes,
    output logic       hit,
    output logic       miss,
    output logic       bad_guess,
    output logic       win,
    output logic       lose
);

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    state_t     state_reg, state_next;
    logic [2:0] seq_reg [6];
    logic [2:0] len_reg;
    logic [2:0] len_in;
    logic [2:0] target;
    logic       load;
    logic       guess_legal;
    logic [2:0] pos_inc;
    logic [1:0] strikes_inc;

    logic [2:0] pos_reg, pos_next;
    logic [1:0] strikes_reg, strikes_next;
    logic       hit_reg, hit_next;
    logic       miss_reg, miss_next;
    logic       bad_reg, bad_next;
    logic       ready_reg, ready_next;
    logic       playing_reg, playing_next;
    logic       win_reg, win_next;
    logic       lose_reg, lose_next;

    always_comb begin
        case (mode)
            2'b00:   len_in = 3'd4;
            2'b01:   len_in = 3'd5;
            default: len_in = 3'd6;
        endcase
    end

    // Expected value for the next unmatched position
    always_comb begin
        case (pos_reg)
            3'd0:    target = seq_reg[0];
            3'd1:    target = seq_reg[1];
            3'd2:    target = seq_reg[2];
            3'd3:    target = seq_reg[3];
            3'd4:    target = seq_reg[4];
            3'd5:    target = seq_reg[5];
            default: target = 3'd0;
        endcase
    end

    assign guess_legal = (guess != 3'd0) && (guess != 3'd7);
    assign pos_inc     = pos_reg + 3'd1;
    assign strikes_inc = strikes_reg + 2'd1;

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pos_reg     <= 3'd0;
            strikes_reg <= 2'd0;
            hit_reg     <= 1'b0;
            miss_reg    <= 1'b0;
            bad_reg     <= 1'b0;
            ready_reg   <= 1'b1;
            playing_reg <= 1'b0;
            win_reg     <= 1'b0;
            lose_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pos_reg     <= pos_next;
            strikes_reg <= strikes_next;
            hit_reg     <= hit_next;
            miss_reg    <= miss_next;
            bad_reg     <= bad_next;
            ready_reg   <= ready_next;
            playing_reg <= playing_next;
            win_reg     <= win_next;
            lose_reg    <= lose_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) seq_reg[i] <= 3'd0;
            len_reg <= 3'd0;
        end else if (load) begin
            seq_reg[0] <= index1;
            seq_reg[1] <= index2;
            seq_reg[2] <= index3;
            seq_reg[3] <= index4;
            seq_reg[4] <= index5;
            seq_reg[5] <= index6;
            len_reg    <= len_in;
        end
    end

    // Next-state and datapath updates; done outranks any same-cycle guess
    always_comb begin
        state_next   = state_reg;
        pos_next     = pos_reg;
        strikes_next = strikes_reg;
        hit_next     = 1'b0;
        miss_next    = 1'b0;
        bad_next     = 1'b0;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (done) begin
                    load         = 1'b1;
                    pos_next     = 3'd0;
                    strikes_next = 2'd0;
                    state_next   = PLAY;
                end
            end
            PLAY: begin
                if (done) begin
                    load         = 1'b1;
                    pos_next     = 3'd0;
                    strikes_next = 2'd0;
                end else if (guess_valid) begin
                    if (!guess_legal) begin
                        bad_next = 1'b1;
                    end else if (guess == target) begin
                        hit_next = 1'b1;
                        pos_next = pos_inc;
                        if (pos_inc == len_reg) state_next = WIN;
                    end else begin
                        miss_next    = 1'b1;
                        strikes_next = strikes_inc;
                        if (strikes_inc == 2'(MAX_STRIKES)) state_next = LOSE;
                    end
                end
            end
            default: begin
                if (restart) begin
                    state_next   = IDLE;
                    pos_next     = 3'd0;
                    strikes_next = 2'd0;
                end
            end
        endcase
    end

    always_comb begin
        ready_next   = (state_next == IDLE);
        playing_next = (state_next == PLAY);
        win_next     = (state_next == WIN);
        lose_next    = (state_next == LOSE);
    end

    assign ready     = ready_reg;
    assign playing   = playing_reg;
    assign pos       = pos_reg;
    assign strikes   = strikes_reg;
    assign hit       = hit_reg;
    assign miss      = miss_reg;
    assign bad_guess = bad_reg;
    assign win       = win_reg;
    assign lose      = lose_reg;

endmodule

// File: tb/tb_scramble_checker.sv
// Directed bench for scramble_checker: reset, win, lose, bad guess, done priority
// and round-length capture, each scenario checked inline against hand-derived values.
module tb_scramble_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [1:0] mode;
    logic [2:0] index1, index2, index3, index4, index5, index6;
    logic [2:0] guess;
    logic       guess_valid;
    logic       restart;
    logic       ready, playing, hit, miss, bad_guess, win, lose;
    logic [2:0] pos;
    logic [1:0] strikes;

    int n_cmp = 0;
    int n_err = 0;

    scramble_checker #(.MAX_STRIKES(3)) dut (
        .clk(clk), .rst(rst), .done(done), .mode(mode),
        .index1(index1), .index2(index2), .index3(index3),
        .index4(index4), .index5(index5), .index6(index6),
        .guess(guess), .guess_valid(guess_valid), .restart(restart),
        .ready(ready), .playing(playing), .pos(pos), .strikes(strikes),
        .hit(hit), .miss(miss), .bad_guess(bad_guess), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq(input logic [1:0] m, input logic [2:0] a, b, c, d, e, f);
        mode = m; index1 = a; index2 = b; index3 = c; index4 = d; index5 = e; index6 = f;
    endtask

    task automatic load(input logic [1:0] m, input logic [2:0] a, b, c, d, e, f);
        set_seq(m, a, b, c, d, e, f);
        done = 1'b1;
        cycle();
        done = 1'b0;
        $display("load mode=%0d seq=%0d%0d%0d%0d%0d%0d -> ready=%0b playing=%0b pos=%0d",
                 m, a, b, c, d, e, f, ready, playing, pos);
    endtask

    task automatic do_guess(input logic [2:0] g);
        guess = g;
        guess_valid = 1'b1;
        cycle();
        guess_valid = 1'b0;
        $display("guess %0d -> hit=%0b miss=%0b bad=%0b pos=%0d strikes=%0d win=%0b lose=%0b",
                 g, hit, miss, bad_guess, pos, strikes, win, lose);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        $display("restart -> ready=%0b playing=%0b win=%0b lose=%0b pos=%0d",
                 ready, playing, win, lose, pos);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({ready, playing, win, lose} !== 4'b1000) begin n_err++; $display("FAIL reset_flags: got %b want 1000", {ready, playing, win, lose}); end
        n_cmp++; if ({pos, strikes, hit, miss, bad_guess} !== 8'd0) begin n_err++; $display("FAIL reset_counts: got pos=%0d strikes=%0d pulses=%b want 0", pos, strikes, {hit, miss, bad_guess}); end
        @(negedge clk);
        rst = 1'b0;
        load(2'b00, 3, 1, 4, 2, 6, 5);
        n_cmp++; if (playing !== 1'b1) begin n_err++; $display("FAIL first_done_playing: got %b want 1", playing); end
        do_guess(3);
        do_guess(1);
        n_cmp++; if (pos !== 3'd2) begin n_err++; $display("FAIL pre_reset_pos: got %0d want 2", pos); end
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-round -> ready=%0b playing=%0b pos=%0d", ready, playing, pos);
        n_cmp++; if ({ready, playing, win, lose} !== 4'b1000) begin n_err++; $display("FAIL midround_reset_flags: got %b want 1000", {ready, playing, win, lose}); end
        n_cmp++; if ({pos, strikes} !== 5'd0) begin n_err++; $display("FAIL midround_reset_counts: got pos=%0d strikes=%0d want 0", pos, strikes); end
        rst = 1'b0;
    endtask

    task automatic test_win();
        int hits = 0;
        logic [2:0] seq [4] = '{3'd3, 3'd1, 3'd4, 3'd2};
        load(2'b00, 3, 1, 4, 2, 6, 5);
        n_cmp++; if ({playing, pos, strikes} !== 6'b100000) begin n_err++; $display("FAIL win_load: got playing=%b pos=%0d strikes=%0d want 1,0,0", playing, pos, strikes); end
        for (int i = 0; i < 4; i++) begin
            do_guess(seq[i]);
            if (hit === 1'b1) hits++;
            n_cmp++; if (pos !== 3'(i + 1)) begin n_err++; $display("FAIL win_pos%0d: got %0d want %0d", i, pos, i + 1); end
        end
        n_cmp++; if (hits !== 4) begin n_err++; $display("FAIL win_hits: got %0d want 4", hits); end
        n_cmp++; if ({win, lose, playing, ready} !== 4'b1000) begin n_err++; $display("FAIL win_flags: got %b want 1000", {win, lose, playing, ready}); end
        do_guess(6);
        n_cmp++; if ({hit, miss, bad_guess, win, pos} !== 7'b0001100) begin n_err++; $display("FAIL win_hold: got pulses=%b win=%b pos=%0d want 000,1,4", {hit, miss, bad_guess}, win, pos); end
        do_restart();
        n_cmp++; if ({ready, playing, win, lose, pos} !== 7'b1000000) begin n_err++; $display("FAIL win_restart: got %b want 1000000", {ready, playing, win, lose, pos}); end
    endtask

    task automatic test_lose();
        load(2'b10, 1, 2, 3, 4, 5, 6);
        do_guess(2);
        n_cmp++; if ({miss, hit, strikes, pos} !== 7'b1001000) begin n_err++; $display("FAIL lose_miss1: got miss=%b hit=%b strikes=%0d pos=%0d want 1,0,1,0", miss, hit, strikes, pos); end
        do_guess(1);
        n_cmp++; if ({hit, miss, pos} !== 5'b10001) begin n_err++; $display("FAIL lose_hit: got hit=%b miss=%b pos=%0d want 1,0,1", hit, miss, pos); end
        do_guess(5);
        do_guess(5);
        n_cmp++; if ({pos, strikes, lose, win, playing} !== 8'b00111100) begin n_err++; $display("FAIL lose_end: got pos=%0d strikes=%0d lose=%b win=%b playing=%b want 1,3,1,0,0", pos, strikes, lose, win, playing); end
        do_guess(3);
        n_cmp++; if ({hit, miss, bad_guess, strikes, pos} !== 8'b00011001) begin n_err++; $display("FAIL lose_ignore_guess: got pulses=%b strikes=%0d pos=%0d want 000,3,1", {hit, miss, bad_guess}, strikes, pos); end
        load(2'b00, 6, 5, 4, 3, 2, 1);
        n_cmp++; if ({lose, playing, pos} !== 5'b10001) begin n_err++; $display("FAIL lose_ignore_done: got lose=%b playing=%b pos=%0d want 1,0,1", lose, playing, pos); end
        do_restart();
        n_cmp++; if ({ready, lose, strikes, pos} !== 7'b1000000) begin n_err++; $display("FAIL lose_restart: got ready=%b lose=%b strikes=%0d pos=%0d want 1,0,0,0", ready, lose, strikes, pos); end
    endtask

    task automatic test_bad_guess();
        int bads = 0;
        load(2'b00, 3, 1, 4, 2, 6, 5);
        do_guess(3);
        do_guess(5);
        do_guess(0);
        if (bad_guess === 1'b1) bads++;
        n_cmp++; if ({hit, miss, pos, strikes} !== 7'b0000101) begin n_err++; $display("FAIL bad0_state: got hit=%b miss=%b pos=%0d strikes=%0d want 0,0,1,1", hit, miss, pos, strikes); end
        do_guess(7);
        if (bad_guess === 1'b1) bads++;
        n_cmp++; if (bads !== 2) begin n_err++; $display("FAIL bad_count: got %0d want 2", bads); end
        n_cmp++; if ({pos, strikes} !== 5'b00101) begin n_err++; $display("FAIL bad7_state: got pos=%0d strikes=%0d want 1,1", pos, strikes); end
        cycle();
        n_cmp++; if (bad_guess !== 1'b0) begin n_err++; $display("FAIL bad_pulse_width: got %b want 0", bad_guess); end
        do_restart();
        n_cmp++; if ({playing, ready, pos} !== 5'b10001) begin n_err++; $display("FAIL restart_in_play: got playing=%b ready=%b pos=%0d want 1,0,1", playing, ready, pos); end
    endtask

    task automatic test_priority();
        do_guess(1);
        do_guess(4);
        n_cmp++; if (pos !== 3'd3) begin n_err++; $display("FAIL prio_setup_pos: got %0d want 3", pos); end
        set_seq(2'b00, 6, 5, 4, 3, 2, 1);
        done = 1'b1;
        guess = 3'd2;
        guess_valid = 1'b1;
        cycle();
        done = 1'b0;
        guess_valid = 1'b0;
        $display("done+guess 2 -> hit=%0b miss=%0b pos=%0d strikes=%0d playing=%0b", hit, miss, pos, strikes, playing);
        n_cmp++; if ({hit, miss, pos, strikes, playing} !== 8'b00000001) begin n_err++; $display("FAIL prio_reload: got hit=%b miss=%b pos=%0d strikes=%0d playing=%b want 0,0,0,0,1", hit, miss, pos, strikes, playing); end
        do_guess(6);
        n_cmp++; if ({hit, miss, pos} !== 5'b10001) begin n_err++; $display("FAIL prio_new_seq: got hit=%b miss=%b pos=%0d want 1,0,1", hit, miss, pos); end
    endtask

    task automatic test_mode();
        rst = 1'b1;
        #2 rst = 1'b0;
        load(2'b01, 2, 4, 6, 1, 3, 5);
        set_seq(2'b00, 7, 7, 7, 7, 7, 7);
        do_guess(2);
        do_guess(4);
        do_guess(6);
        do_guess(1);
        n_cmp++; if ({pos, win, playing} !== 5'b10001) begin n_err++; $display("FAIL mode_after4: got pos=%0d win=%b playing=%b want 4,0,1", pos, win, playing); end
        do_guess(3);
        n_cmp++; if ({pos, win, hit} !== 5'b10111) begin n_err++; $display("FAIL mode_after5: got pos=%0d win=%b hit=%b want 5,1,1", pos, win, hit); end
        do_restart();
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; guess = 3'd0; guess_valid = 1'b0; restart = 1'b0;
        set_seq(2'b00, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_win();
        test_lose();
        test_bad_guess();
        test_priority();
        test_mode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
